// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the EX-stage ALU.
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_AND  = 4'h1;
  localparam logic [3:0] ALU_XOR  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_SUB  = 4'h4;
  localparam logic [3:0] ALU_ADC  = 4'h5;
  localparam logic [3:0] ALU_SBC  = 4'h6;
  localparam logic [3:0] ALU_RSB  = 4'h7;
  localparam logic [3:0] ALU_BIC  = 4'h8;
  localparam logic [3:0] ALU_MOV  = 4'h9;
  localparam logic [3:0] ALU_MVN  = 4'hA;
  localparam logic [3:0] ALU_LSL  = 4'hB;
  localparam logic [3:0] ALU_LSR  = 4'hC;
  localparam logic [3:0] ALU_ASR  = 4'hD;
  localparam logic [3:0] ALU_MUL  = 4'hE;
  localparam logic [3:0] ALU_PASS = 4'hF;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;
  logic             run;

  // prod is the accumulator after the current step; valid as the final product when done
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = run && (cnt == CW'(1));

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
      run    <= 1'b1;
    end else if (run) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// EX-stage ALU: registered result with valid/ready, NZCV flag register, barrel shifter, sequential MUL.
module alu_pipe import alu_pkg::*; #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] OP_X,
  input  logic [WIDTH-1:0] OP_Y,
  input  logic [3:0]       ALU_CTRL,
  input  logic             SET_FLAGS,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [3:0]       NZCV,
  output logic             BUSY
);
  state_t           state;
  logic             sf_q;
  logic             cf, accept, is_mul, mul_done, wr_en, wr_sf;
  logic [WIDTH-1:0] mul_prod, res, wr_data;
  logic [3:0]       wr_flags;

  assign cf       = NZCV[FLG_C];
  assign IN_READY = (state == ST_IDLE) && (!OUT_VALID || OUT_READY);
  assign accept   = IN_VALID && IN_READY;
  assign is_mul   = (ALU_CTRL == ALU_MUL);

  // Adder: subtracts are X + ~Y + cin so carry-out reads as "no borrow"
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_ci, add_v;
  logic [WIDTH:0]   sum;

  always_comb begin
    add_a  = OP_X;
    add_b  = OP_Y;
    add_ci = 1'b0;
    case (ALU_CTRL)
      ALU_ADC: add_ci = cf;
      ALU_SUB: begin add_b = ~OP_Y; add_ci = 1'b1; end
      ALU_SBC: begin add_b = ~OP_Y; add_ci = cf;   end
      ALU_RSB: begin add_a = OP_Y; add_b = ~OP_X; add_ci = 1'b1; end
      default: ;
    endcase
  end

  assign sum   = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
  assign add_v = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);

  // Shifts run one bit wider so the last bit shifted out lands in the extra position
  logic [SHW-1:0] amt;
  logic [WIDTH:0] lsl_ext, lsr_ext, asr_ext;

  assign amt     = OP_Y[SHW-1:0];
  assign lsl_ext = {1'b0, OP_X} << amt;
  assign lsr_ext = {OP_X, 1'b0} >> amt;
  assign asr_ext = $unsigned($signed({OP_X, 1'b0}) >>> amt);

  logic c_new, v_new;

  always_comb begin
    res   = OP_X;
    c_new = cf;
    v_new = NZCV[FLG_V];
    case (ALU_CTRL)
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_RSB: begin
        res   = sum[WIDTH-1:0];
        c_new = sum[WIDTH];
        v_new = add_v;
      end
      ALU_AND: res = OP_X & OP_Y;
      ALU_XOR: res = OP_X ^ OP_Y;
      ALU_OR:  res = OP_X | OP_Y;
      ALU_BIC: res = OP_X & ~OP_Y;
      ALU_MOV: res = OP_Y;
      ALU_MVN: res = ~OP_Y;
      ALU_LSL: begin res = lsl_ext[WIDTH-1:0]; if (amt != '0) c_new = lsl_ext[WIDTH]; end
      ALU_LSR: begin res = lsr_ext[WIDTH:1];   if (amt != '0) c_new = lsr_ext[0];     end
      ALU_ASR: begin res = asr_ext[WIDTH:1];   if (amt != '0) c_new = asr_ext[0];     end
      default: res = OP_X;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .gclk  (CLK),
    .grst_n(RST_N),
    .start (accept && is_mul),
    .a     (OP_X),
    .b     (OP_Y),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // One write port: either a single-cycle op at accept or the multiplier's last step
  always_comb begin
    wr_en    = accept && !is_mul;
    wr_data  = res;
    wr_sf    = SET_FLAGS;
    wr_flags = {res[WIDTH-1], res == '0, c_new, v_new};
    if (state == ST_MUL) begin
      wr_en    = mul_done;
      wr_data  = mul_prod;
      wr_sf    = sf_q;
      wr_flags = {mul_prod[WIDTH-1], mul_prod == '0, NZCV[FLG_C], NZCV[FLG_V]};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      BUSY      <= 1'b0;
      sf_q      <= 1'b0;
      OUT_VALID <= 1'b0;
      ALU_OUT   <= '0;
      NZCV      <= '0;
    end else begin
      if (accept && is_mul) begin
        state <= ST_MUL;
        BUSY  <= 1'b1;
        sf_q  <= SET_FLAGS;
      end else if (state == ST_MUL && mul_done) begin
        state <= ST_IDLE;
        BUSY  <= 1'b0;
      end
      if (wr_en) begin
        ALU_OUT   <= wr_data;
        OUT_VALID <= 1'b1;
        if (wr_sf) NZCV <= wr_flags;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end
endmodule
